// File: rtl/layer_ctrl_pkg.sv
// layer_ctrl_pkg: sequencer state encoding and datapath mux select constants
package layer_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ROUND, S_OUTPUT, S_DONE} state_t;
  localparam logic [1:0] WC_L0      = 2'd0;
  localparam logic [1:0] WC_FB_LOAD = 2'd1;
  localparam logic [1:0] WC_FB_MAC  = 2'd2;
  localparam logic [1:0] WC_IDLE    = 2'd3;
  function automatic logic [1:0] wc_of(state_t s, logic l0);
    return s == S_LOAD ? (l0 ? WC_L0 : WC_FB_LOAD) :
           s == S_MAC  ? (l0 ? WC_L0 : WC_FB_MAC)  : WC_IDLE;
  endfunction
endpackage

// File: rtl/layer_seq_ctrl_wrap_cnt.sv
// wrap_cnt: up-counter wrapping to 0 after MAX-1, sync clear over enable, terminal flag last_o
module wrap_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt_o,
  output logic             last_o
);
  assign last_o = cnt_o == WIDTH'(MAX - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_o <= '0;
    else if (clr) cnt_o <= '0;
    else if (en) cnt_o <= last_o ? '0 : cnt_o + 1'b1;
endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: NUM_LAYERS x TILES load/MAC/round/output sequencer; CTRL_PERF_CNT_EN adds perf_cycles_o/perf_stall_o
module layer_seq_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS   = 8,
  parameter int TILES        = 16,
  parameter int MAC_CYCLES   = 8,
  parameter int ROUND_CYCLES = 8,
  parameter int OUT_WORDS    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          data_rdy_i,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic                          read_en_o,
  output logic                          acc_clr_o,
  output logic                          mac_en_o,
  output logic                          round_en_o,
  output logic [1:0]                    wire_connect_o,
  output logic [$clog2(NUM_LAYERS):0]   layer_idx_o,
  output logic [$clog2(TILES):0]        tile_idx_o,
  output logic                          out_valid_o,
  output logic                          done_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_cycles_o,
  output logic [31:0]                   perf_stall_o
`endif
);
  localparam int CYC_MAX = MAC_CYCLES > ROUND_CYCLES ? MAC_CYCLES : ROUND_CYCLES;
  localparam int CW = $clog2(CYC_MAX) + 1;
  localparam int WW = $clog2(OUT_WORDS) + 1;
  state_t state, nxt;
  logic [CW-1:0] cyc;
  logic [WW-1:0] unused_word_cnt;
  logic cyc_full, cyc_last, tile_last, layer_last, word_last, layer0, load_go, hs, idle_clr;
  logic cyc_en, cyc_clr, tile_en, tile_clr, layer_en, nxt_tile0, nxt_layer0;
  assign layer0    = layer_idx_o == '0;
  assign load_go   = state == S_LOAD && (!layer0 || data_rdy_i);
  assign read_en_o = load_go && !abort_i;
  assign hs        = out_valid_o && out_ready_i;
  assign idle_clr  = abort_i || state == S_IDLE;
  // the longer phase ends on the counter's own terminal flag, the shorter on its compare
  assign cyc_last  = cyc_full || cyc == (state == S_MAC ? CW'(MAC_CYCLES - 1) : CW'(ROUND_CYCLES - 1));
  assign cyc_en    = state == S_MAC || state == S_ROUND;
  assign cyc_clr   = idle_clr || cyc_last;
  assign tile_en   = state == S_MAC && cyc_last && !tile_last;
  assign layer_en  = state == S_ROUND && cyc_last && !layer_last;
  assign tile_clr  = idle_clr || layer_en;
  assign nxt_tile0  = tile_clr || (tile_idx_o == '0 && !tile_en);
  assign nxt_layer0 = idle_clr || (layer0 && !layer_en);
  always_comb begin
    nxt = state;
    if (abort_i) nxt = S_IDLE;
    else case (state)
      S_IDLE:   if (start_i) nxt = S_LOAD;
      S_LOAD:   if (load_go) nxt = S_MAC;
      S_MAC:    if (cyc_last) nxt = tile_last ? S_ROUND : S_LOAD;
      S_ROUND:  if (cyc_last) nxt = layer_last ? S_OUTPUT : S_LOAD;
      S_OUTPUT: if (hs && word_last) nxt = S_DONE;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= S_IDLE;
      busy_o         <= 1'b0;
      acc_clr_o      <= 1'b0;
      mac_en_o       <= 1'b0;
      round_en_o     <= 1'b0;
      out_valid_o    <= 1'b0;
      done_o         <= 1'b0;
      wire_connect_o <= WC_IDLE;
    end else begin
      state          <= nxt;
      busy_o         <= nxt != S_IDLE;
      acc_clr_o      <= nxt == S_LOAD && nxt_tile0;
      mac_en_o       <= nxt == S_MAC;
      round_en_o     <= nxt == S_ROUND;
      out_valid_o    <= nxt == S_OUTPUT;
      done_o         <= nxt == S_DONE;
      wire_connect_o <= wc_of(nxt, nxt_layer0);
    end
  wrap_cnt #(.WIDTH(CW), .MAX(CYC_MAX)) u_cyc (
    .clk(clk), .rst_n(rst_n), .en(cyc_en), .clr(cyc_clr), .cnt_o(cyc), .last_o(cyc_full));
  wrap_cnt #(.WIDTH($clog2(TILES) + 1), .MAX(TILES)) u_tile (
    .clk(clk), .rst_n(rst_n), .en(tile_en), .clr(tile_clr), .cnt_o(tile_idx_o), .last_o(tile_last));
  wrap_cnt #(.WIDTH($clog2(NUM_LAYERS) + 1), .MAX(NUM_LAYERS)) u_layer (
    .clk(clk), .rst_n(rst_n), .en(layer_en), .clr(idle_clr), .cnt_o(layer_idx_o), .last_o(layer_last));
  wrap_cnt #(.WIDTH(WW), .MAX(OUT_WORDS)) u_word (
    .clk(clk), .rst_n(rst_n), .en(hs), .clr(idle_clr), .cnt_o(unused_word_cnt), .last_o(word_last));
`ifdef CTRL_PERF_CNT_EN
  logic stall;
  assign stall = (state == S_LOAD && layer0 && !data_rdy_i) || (state == S_OUTPUT && !out_ready_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (state == S_IDLE && start_i && !abort_i) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (busy_o && !(&perf_cycles_o)) perf_cycles_o <= perf_cycles_o + 1'b1;
      if (stall && !(&perf_stall_o)) perf_stall_o <= perf_stall_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: directed checks of the layer sequencer with default and minimal parameters
module tb_layer_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, data_rdy_i = 1'b1, out_ready_i = 1'b1;
  logic busy_o, read_en_o, acc_clr_o, mac_en_o, round_en_o, out_valid_o, done_o;
  logic [1:0] wire_connect_o;
  logic [3:0] layer_idx_o;
  logic [4:0] tile_idx_o;
  logic s_start = 1'b0, s_abort = 1'b0, s_rdy = 1'b1, s_ordy = 1'b1;
  logic s_busy, s_read, s_clr, s_mac, s_round, s_valid, s_done;
  logic [1:0] s_wc;
  logic [0:0] s_layer, s_tile;
  int tests_run = 0, tests_failed = 0;
  int m_first_valid, m_last_valid, m_valid_cnt, m_done_cyc, m_done_cnt, m_read_cnt, m_mac_cnt;
  int m_round_cnt, m_clr_cnt, m_stall_read, m_wc0, m_wc1, m_wc2, m_busy_after_abort, m_out_layer;
  int m_out_tile, m_busy1;
  always #5 clk = ~clk;
  layer_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .data_rdy_i(data_rdy_i),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .read_en_o(read_en_o), .acc_clr_o(acc_clr_o),
    .mac_en_o(mac_en_o), .round_en_o(round_en_o), .wire_connect_o(wire_connect_o),
    .layer_idx_o(layer_idx_o), .tile_idx_o(tile_idx_o), .out_valid_o(out_valid_o), .done_o(done_o));
  layer_seq_ctrl #(.NUM_LAYERS(1), .TILES(1), .MAC_CYCLES(1), .ROUND_CYCLES(1), .OUT_WORDS(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(s_abort), .data_rdy_i(s_rdy),
    .out_ready_i(s_ordy), .busy_o(s_busy), .read_en_o(s_read), .acc_clr_o(s_clr),
    .mac_en_o(s_mac), .round_en_o(s_round), .wire_connect_o(s_wc),
    .layer_idx_o(s_layer), .tile_idx_o(s_tile), .out_valid_o(s_valid), .done_o(s_done));
  // start_i is presented in cycle 0, so edge 0 launches the run and cycle k follows edge k
  task automatic run(input int ncyc, input int st_lo, input int st_hi, input int bp_lo,
                     input int bp_hi, input int ab_cyc);
    m_first_valid = -1; m_last_valid = -1; m_valid_cnt = 0; m_done_cyc = -1; m_done_cnt = 0;
    m_read_cnt = 0; m_mac_cnt = 0; m_round_cnt = 0; m_clr_cnt = 0; m_stall_read = 0;
    m_wc0 = 0; m_wc1 = 0; m_wc2 = 0; m_busy_after_abort = -1; m_out_layer = -1; m_out_tile = -1;
    m_busy1 = -1;
    @(posedge clk); #1;
    start_i = 1'b1; abort_i = 1'b0; data_rdy_i = 1'b1; out_ready_i = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      data_rdy_i = !(k >= st_lo && k <= st_hi);
      out_ready_i = !(k >= bp_lo && k <= bp_hi);
      abort_i = k == ab_cyc;
      @(negedge clk);
      if (k == 1) m_busy1 = busy_o;
      if (k == ab_cyc + 1) m_busy_after_abort = busy_o;
      if (read_en_o) begin
        m_read_cnt++;
        if (k >= st_lo && k <= st_hi) m_stall_read++;
      end
      if (mac_en_o) m_mac_cnt++;
      if (round_en_o) m_round_cnt++;
      if (acc_clr_o) m_clr_cnt++;
      if (busy_o && wire_connect_o == 2'd0) m_wc0++;
      if (wire_connect_o == 2'd1) m_wc1++;
      if (wire_connect_o == 2'd2) m_wc2++;
      if (out_valid_o) begin
        if (m_first_valid < 0) begin
          m_first_valid = k; m_out_layer = int'(layer_idx_o); m_out_tile = int'(tile_idx_o);
        end
        m_last_valid = k;
        m_valid_cnt++;
      end
      if (done_o) begin
        if (m_done_cyc < 0) m_done_cyc = k;
        m_done_cnt++;
      end
    end
    abort_i = 1'b0; data_rdy_i = 1'b1; out_ready_i = 1'b1;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy_o, read_en_o, acc_clr_o, mac_en_o, round_en_o, out_valid_o, done_o} !== 7'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b expected 0000000",
        {busy_o, read_en_o, acc_clr_o, mac_en_o, round_en_o, out_valid_o, done_o});
    end
    tests_run++;
    if (wire_connect_o !== 2'd3) begin
      tests_failed++; $display("FAIL reset_wc: got %0d expected 3", wire_connect_o);
    end
    tests_run++;
    if (layer_idx_o !== 4'd0 || tile_idx_o !== 5'd0) begin
      tests_failed++; $display("FAIL reset_idx: got layer %0d tile %0d expected 0 0", layer_idx_o, tile_idx_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0 || wire_connect_o !== 2'd3) begin
      tests_failed++; $display("FAIL idle_after_reset: got busy %b wc %0d expected 0 3", busy_o, wire_connect_o);
    end
  endtask
  task automatic test_start_abort;
    @(posedge clk); #1;
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL start_with_abort: got busy %b expected 0", busy_o);
    end
  endtask
  task automatic test_full_run;
    run(1225, -1, -2, -1, -2, -1);
    tests_run++;
    if (m_busy1 !== 1) begin tests_failed++; $display("FAIL full_busy_c1: got %0d expected 1", m_busy1); end
    tests_run++;
    if (m_first_valid !== 1217 || m_last_valid !== 1220 || m_valid_cnt !== 4) begin
      tests_failed++; $display("FAIL full_output_window: got %0d..%0d n=%0d expected 1217..1220 n=4",
        m_first_valid, m_last_valid, m_valid_cnt);
    end
    tests_run++;
    if (m_done_cyc !== 1221 || m_done_cnt !== 1) begin
      tests_failed++; $display("FAIL full_done: got cycle %0d n=%0d expected 1221 n=1", m_done_cyc, m_done_cnt);
    end
    tests_run++;
    if (m_mac_cnt !== 1024 || m_round_cnt !== 64) begin
      tests_failed++; $display("FAIL full_en_counts: got mac %0d round %0d expected 1024 64", m_mac_cnt, m_round_cnt);
    end
    tests_run++;
    if (m_read_cnt !== 128 || m_clr_cnt !== 8) begin
      tests_failed++; $display("FAIL full_read_clr: got read %0d clr %0d expected 128 8", m_read_cnt, m_clr_cnt);
    end
    tests_run++;
    if (m_wc0 !== 144 || m_wc1 !== 112 || m_wc2 !== 896) begin
      tests_failed++; $display("FAIL full_wire_connect: got %0d/%0d/%0d expected 144/112/896", m_wc0, m_wc1, m_wc2);
    end
    tests_run++;
    if (m_out_layer !== 7 || m_out_tile !== 15) begin
      tests_failed++; $display("FAIL full_final_idx: got layer %0d tile %0d expected 7 15", m_out_layer, m_out_tile);
    end
  endtask
  task automatic test_data_stall;
    run(1230, 28, 32, -1, -2, -1);
    tests_run++;
    if (m_stall_read !== 0) begin
      tests_failed++; $display("FAIL stall_read_en: got %0d reads expected 0", m_stall_read);
    end
    tests_run++;
    if (m_done_cyc !== 1226 || m_done_cnt !== 1) begin
      tests_failed++; $display("FAIL stall_done: got cycle %0d n=%0d expected 1226 n=1", m_done_cyc, m_done_cnt);
    end
    tests_run++;
    if (m_read_cnt !== 128) begin
      tests_failed++; $display("FAIL stall_read_total: got %0d expected 128", m_read_cnt);
    end
  endtask
  task automatic test_backpressure;
    run(1230, -1, -2, 1218, 1220, -1);
    tests_run++;
    if (m_first_valid !== 1217 || m_last_valid !== 1223 || m_valid_cnt !== 7) begin
      tests_failed++; $display("FAIL bp_valid_held: got %0d..%0d n=%0d expected 1217..1223 n=7",
        m_first_valid, m_last_valid, m_valid_cnt);
    end
    tests_run++;
    if (m_done_cyc !== 1224 || m_done_cnt !== 1) begin
      tests_failed++; $display("FAIL bp_done: got cycle %0d n=%0d expected 1224 n=1", m_done_cyc, m_done_cnt);
    end
  endtask
  task automatic test_abort;
    run(1230, -1, -2, -1, -2, 450);
    tests_run++;
    if (m_busy_after_abort !== 0) begin
      tests_failed++; $display("FAIL abort_busy: got %0d expected 0", m_busy_after_abort);
    end
    tests_run++;
    if (m_done_cnt !== 0 || m_valid_cnt !== 0) begin
      tests_failed++; $display("FAIL abort_no_done: got done %0d valid %0d expected 0 0", m_done_cnt, m_valid_cnt);
    end
    run(1225, -1, -2, -1, -2, -1);
    tests_run++;
    if (m_done_cyc !== 1221 || m_first_valid !== 1217) begin
      tests_failed++; $display("FAIL abort_restart: got done %0d valid %0d expected 1221 1217", m_done_cyc, m_first_valid);
    end
  endtask
  task automatic test_async_reset;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (mac_en_o !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_mac: got %b expected 1", mac_en_o); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_o, mac_en_o, acc_clr_o, round_en_o, out_valid_o, done_o} !== 6'b0 || wire_connect_o !== 2'd3) begin
      tests_failed++; $display("FAIL areset_outputs: got %b wc %0d expected 000000 wc 3",
        {busy_o, mac_en_o, acc_clr_o, round_en_o, out_valid_o, done_o}, wire_connect_o);
    end
    tests_run++;
    if (layer_idx_o !== 4'd0 || tile_idx_o !== 5'd0) begin
      tests_failed++; $display("FAIL areset_idx: got %0d %0d expected 0 0", layer_idx_o, tile_idx_o);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL areset_idle: got busy %b expected 0", busy_o); end
  endtask
  task automatic test_min_params;
    int e_busy[6], e_mac[6], e_round[6], e_valid[6], e_done[6], e_read[6];
    e_busy = '{1, 1, 1, 1, 1, 0};
    e_read = '{1, 0, 0, 0, 0, 0};
    e_mac = '{0, 1, 0, 0, 0, 0};
    e_round = '{0, 0, 1, 0, 0, 0};
    e_valid = '{0, 0, 0, 1, 0, 0};
    e_done = '{0, 0, 0, 0, 1, 0};
    @(posedge clk); #1;
    s_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      s_start = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({s_busy, s_read, s_mac, s_round, s_valid, s_done} !==
          {e_busy[k-1][0], e_read[k-1][0], e_mac[k-1][0], e_round[k-1][0], e_valid[k-1][0], e_done[k-1][0]}) begin
        tests_failed++;
        $display("FAIL min_cycle%0d: got busy/read/mac/round/valid/done %b expected %b", k,
          {s_busy, s_read, s_mac, s_round, s_valid, s_done},
          {e_busy[k-1][0], e_read[k-1][0], e_mac[k-1][0], e_round[k-1][0], e_valid[k-1][0], e_done[k-1][0]});
      end
      if (k == 1) begin
        tests_run++;
        if (s_clr !== 1'b1 || s_wc !== 2'd0) begin
          tests_failed++; $display("FAIL min_load: got clr %b wc %0d expected 1 0", s_clr, s_wc);
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_start_abort;
    test_full_run;
    test_data_stall;
    test_backpressure;
    test_abort;
    test_async_reset;
    test_min_params;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
